// File: rtl/score_display.sv
// score_display: turns the binary score into 5-digit BCD with a sequential
// double-dabble engine (one shift per clock). It then scans the committed
// digits onto a multiplexed common-cathode 7-segment display.
module score_display #(
    parameter int SCAN_DIV      = 1024,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] score,
    input  logic        score_valid,
    output logic        busy,
    output logic [19:0] bcd,
    output logic [6:0]  seg,
    output logic [4:0]  digit_en
);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

    state_t      r_state, w_state_nxt;
    logic [15:0] r_bin;
    logic [19:0] r_work;
    logic [3:0]  r_cnt;
    logic [19:0] r_bcd;
    logic        r_pend;
    logic [15:0] r_pend_val;
    logic [15:0] r_scan_cnt;
    logic [2:0]  r_idx;

    logic        w_restart;
    logic [15:0] w_load_val;
    logic [15:0] w_adj;
    logic [19:0] w_shift_work;
    logic [3:0]  w_nib;
    logic        w_blank;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state and restart control. During COMMIT, a strobe arriving in the
    // same cycle is newer than anything pending, so it takes priority.
    always_comb begin
        w_state_nxt = r_state;
        w_restart   = 1'b0;
        w_load_val  = score;
        case (r_state)
            IDLE: begin
                if (score_valid) begin
                    w_state_nxt = SHIFT;
                    w_restart   = 1'b1;
                end
            end
            SHIFT: begin
                if (r_cnt == 4'd15) w_state_nxt = COMMIT;
            end
            COMMIT: begin
                if (score_valid || r_pend) begin
                    w_state_nxt = SHIFT;
                    w_restart   = 1'b1;
                    w_load_val  = score_valid ? score : r_pend_val;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Add-3 correction on the four low nibbles.
    // Digit 4 is at most 3 before its final shift, so it never needs the correction.
    always_comb begin
        w_adj = r_work[15:0];
        for (int i = 0; i < 4; i++) begin
            if (r_work[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_work[4*i +: 4] + 4'd3;
        end
        w_shift_work = {r_work[18:16], w_adj, r_bin[15]};
    end

    // Conversion datapath: load, shift, and commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin  <= '0;
            r_work <= '0;
            r_cnt  <= '0;
            r_bcd  <= '0;
        end else begin
            if (r_state == COMMIT) r_bcd <= r_work;
            if (w_restart) begin
                r_bin  <= w_load_val;
                r_work <= '0;
                r_cnt  <= '0;
            end else if (r_state == SHIFT) begin
                r_work <= w_shift_work;
                r_bin  <= {r_bin[14:0], 1'b0};
                r_cnt  <= r_cnt + 4'd1;
            end
        end
    end

    // One-deep pending slot for strobes that arrive mid-conversion; newest wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend     <= 1'b0;
            r_pend_val <= '0;
        end else if (score_valid && r_state == SHIFT) begin
            r_pend     <= 1'b1;
            r_pend_val <= score;
        end else if (r_state == COMMIT) begin
            r_pend     <= 1'b0;
        end
    end

    // Free-running scan: hold each digit SCAN_DIV cycles, then advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt <= '0;
            r_idx      <= '0;
        end else if (r_scan_cnt == SCAN_LAST) begin
            r_scan_cnt <= '0;
            r_idx      <= (r_idx == 3'd4) ? 3'd0 : r_idx + 3'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + 16'd1;
        end
    end

    // Digit select and leading-zero detection for the scanned digit
    always_comb begin
        w_nib   = r_bcd[3:0];
        w_blank = 1'b0;
        case (r_idx)
            3'd1: begin w_nib = r_bcd[7:4];   w_blank = (r_bcd[19:4]  == '0); end
            3'd2: begin w_nib = r_bcd[11:8];  w_blank = (r_bcd[19:8]  == '0); end
            3'd3: begin w_nib = r_bcd[15:12]; w_blank = (r_bcd[19:12] == '0); end
            3'd4: begin w_nib = r_bcd[19:16]; w_blank = (r_bcd[19:16] == '0); end
            default: begin w_nib = r_bcd[3:0]; w_blank = 1'b0; end
        endcase
        if (!BLANK_LEADING) w_blank = 1'b0;
    end

    // Seven-segment decode, {g,f,e,d,c,b,a}, active-high
    always_comb begin
        seg = 7'h00;
        if (!w_blank) begin
            case (w_nib)
                4'd0: seg = 7'h3F;
                4'd1: seg = 7'h06;
                4'd2: seg = 7'h5B;
                4'd3: seg = 7'h4F;
                4'd4: seg = 7'h66;
                4'd5: seg = 7'h6D;
                4'd6: seg = 7'h7D;
                4'd7: seg = 7'h07;
                4'd8: seg = 7'h7F;
                4'd9: seg = 7'h6F;
                default: seg = 7'h00;
            endcase
        end
    end

    // Output drive
    always_comb begin
        busy     = (r_state != IDLE);
        bcd      = r_bcd;
        digit_en = 5'b00001 << r_idx;
    end

endmodule

// File: doc/score_display.md
Name: score_display

Overview:
- Consumer end of the score interface: accepts the 16-bit binary score word and the score-update strobe from the score counter.
- Converts the score to 5-digit BCD with a sequential double-dabble engine (one shift per clock).
- Drives a time-multiplexed 5-digit common-cathode 7-segment display with leading-zero blanking.
- Sits between the score counter and the board display pins.

Parameters:
- SCAN_DIV, 1024: clock cycles each digit stays enabled before the scan advances (legal range 2..65535).
- BLANK_LEADING, 1: 1 = blank leading zero digits; 0 = show all five digits.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous assert, active-low
- score  input  16  binary score from the score counter; sampled only on score_valid
- score_valid  input  1  single-cycle strobe: a new score is present
- busy  output  1  conversion in progress
- bcd  output  20  committed BCD value; digit4 in [19:16] ... digit0 in [3:0]
- seg  output  7  segment drive, active-high, bit order {g,f,e,d,c,b,a}
- digit_en  output  5  one-hot digit enable, active-high; bit0 = least significant digit

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM = IDLE; busy = 0; bcd = 0; pending flag = 0.
  - Scan counter = 0; digit index = 0; digit_en = 5'b00001; seg = 7'b0111111 (a "0" on digit 0).
  - Release is synchronous to clk.
- Conversion FSM states: IDLE, SHIFT, COMMIT.
  - IDLE: if score_valid is sampled high at edge E0, latch score into the shift register, clear the BCD working register and shift count, go to SHIFT.
  - SHIFT: one double-dabble step per edge, E1..E16. Each step adds 3 to every working BCD nibble >= 5, then shifts {bcd_work, bin} left by 1. After the 16th shift, go to COMMIT.
  - COMMIT: at E17, copy the working register into bcd. If the pending flag is set, reload from the pending register and go to SHIFT; otherwise go to IDLE.
  - busy = (state != IDLE): high from after E0 through E17 for an isolated update.
  - Latency: bcd is updated after E17, i.e. 17 cycles after the strobe edge.
- Strobe while busy: store score in a one-deep pending register and set the pending flag. A later strobe before that restart overwrites the pending value; only the newest score is kept.
- Strobe in the same cycle as COMMIT: treated as pending; conversion restarts directly, with no IDLE cycle.
- Width rules:
  - Working register is 20 bits BCD + 16 bits binary.
  - 65535 converts to 0x65535 with no overflow; digit4 <= 6 by construction.
  - bcd never holds a non-decimal nibble.
- Scan:
  - Free-running counter 0..SCAN_DIV-1.
  - On terminal count, digit index advances 0->1->2->3->4->0 and the counter returns to 0.
  - digit_en is the one-hot decode of the registered index.
  - The scan runs independently of the conversion FSM and always displays the committed bcd, never the working register.
- Segment decode (combinational from index and bcd):
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F (hex, {g..a}).
- Blanking (BLANK_LEADING=1):
  - Digit k (k >= 1) outputs seg = 0 when it and all higher digits are zero.
  - Digit 0 is never blanked.
  - digit_en still cycles normally.
- Reset mid-conversion:
  - Conversion is aborted; bcd returns to 0 and the pending value is discarded.
  - After release, the block waits for a new strobe.

Test Plan:
1. Reset, then score=12345 with a one-cycle score_valid -> busy high for 17 cycles; bcd = 20'h12345 after E17; busy low after E17.
2. score=65535 strobe -> bcd = 20'h65535. Then score=0 strobe -> bcd = 20'h00000; digits 1-4 output seg = 0; digit 0 outputs 7'h3F.
3. SCAN_DIV=4, bcd = 20'h00907:
   - digit_en sequence 00001,00010,00100,01000,10000,00001, each held 4 cycles.
   - seg sequence 07,3F,6F,00,00.
   - With BLANK_LEADING=0, digits 3 and 4 show 3F.
4. Strobe 100, then strobe 200 at cycle 5 and 300 at cycle 9 of the conversion:
   - bcd = 0x00100 after the first COMMIT.
   - Conversion restarts with no idle gap and ends with bcd = 0x00300.
   - 200 is never committed.
5. Strobe 4321; assert rst_n low at SHIFT cycle 8 for 2 cycles -> bcd = 0 and busy = 0 immediately (asynchronous). No commit occurs afterwards; a new strobe of 9 gives bcd = 0x00009.
